// File: rtl/tmnt_audio_pkg.sv
// Shared audio types: note indices, oscillator FSM states and period counts.
package tmnt_audio_pkg;

  localparam int NUM_NOTES = 12;

  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  typedef enum logic [1:0] {
    OSC_IDLE,
    OSC_PLAY,
    OSC_STOP
  } osc_state_t;

  typedef logic [15:0] period_t;

  // All twelve per-note period counts, index 0 = C.
  typedef logic [NUM_NOTES-1:0][15:0] div_bank_t;

endpackage

// File: rtl/note_oscillator_if.sv
// Bundle between the divider stage / mixer and the note oscillator.
interface note_oscillator_if;
  import tmnt_audio_pkg::*;

  div_bank_t          div;
  logic [3:0]         note_sel;
  logic               key_on;
  logic               wave;
  logic signed [7:0]  sample;
  logic               period_tick;
  logic               active;

  modport master (
    output div, note_sel, key_on,
    input  wave, sample, period_tick, active
  );

  modport slave (
    input  div, note_sel, key_on,
    output wave, sample, period_tick, active
  );

endinterface

// File: rtl/note_div_mux.sv
// Selects one note's period count, clamps it up to MIN_DIV and flags invalid note indices.
module note_div_mux
  import tmnt_audio_pkg::*;
#(
  parameter period_t MIN_DIV = 16'd2
) (
  input  div_bank_t  div,
  input  logic [3:0] note_sel,
  output period_t    sel_div,
  output logic       valid
);

  period_t raw;

  always_comb begin
    valid = (note_sel < 4'(NUM_NOTES));
    raw   = '0;
    if (valid) begin
      raw = div[note_sel];
    end
    sel_div = (raw < MIN_DIV) ? MIN_DIV : raw;
  end

endmodule

// File: rtl/note_oscillator.sv
// Square-wave note oscillator; selection changes are only picked up at period boundaries
// so a period is never truncated.
module note_oscillator
  import tmnt_audio_pkg::*;
#(
  parameter logic signed [7:0] AMPLITUDE = 8'sd64,
  parameter period_t           MIN_DIV   = 16'd2
) (
  input logic              clk,
  input logic              rst,
  note_oscillator_if.slave osc
);

  osc_state_t state, state_nxt;
  period_t    count, count_nxt;
  period_t    div_act, div_act_nxt;
  period_t    sel_div;
  period_t    half;
  logic       sel_valid;
  logic       req;
  logic       wrap;
  logic       running;

  note_div_mux #(
    .MIN_DIV (MIN_DIV)
  ) u_div_mux (
    .div      (osc.div),
    .note_sel (osc.note_sel),
    .sel_div  (sel_div),
    .valid    (sel_valid)
  );

  assign req     = osc.key_on && sel_valid;
  assign half    = div_act >> 1;
  assign wrap    = (count == div_act - 16'd1);
  assign running = (state == OSC_PLAY) || (state == OSC_STOP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= OSC_IDLE;
      count   <= '0;
      div_act <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      div_act <= div_act_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    div_act_nxt = div_act;
    case (state)
      OSC_IDLE: begin
        if (req) begin
          state_nxt   = OSC_PLAY;
          count_nxt   = '0;
          div_act_nxt = sel_div;
        end
      end
      // PLAY and STOP run the counter identically; only req at the wrap decides reload vs. idle.
      OSC_PLAY, OSC_STOP: begin
        if (wrap) begin
          count_nxt = '0;
          if (req) begin
            state_nxt   = OSC_PLAY;
            div_act_nxt = sel_div;
          end else begin
            state_nxt = OSC_IDLE;
          end
        end else begin
          count_nxt = count + 16'd1;
          state_nxt = req ? OSC_PLAY : OSC_STOP;
        end
      end
      default: begin
        state_nxt = OSC_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // Outputs decode only registered state, so there is no input-to-output path.
  assign osc.wave        = running && (count < half);
  assign osc.sample      = !running ? 8'sd0 : (osc.wave ? AMPLITUDE : -AMPLITUDE);
  assign osc.period_tick = running && wrap;
  assign osc.active      = running;

endmodule

// File: tb/tb_note_oscillator.sv
// Directed bench for note_oscillator: period shape table plus multi-period boundary sequences.
module tb_note_oscillator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  note_oscillator_if osc_if ();

  note_oscillator dut (
    .clk (clk),
    .rst (rst),
    .osc (osc_if.slave)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [3:0]  note;
    logic [15:0] dv;
    int          exp_hi;
    int          exp_lo;
    int          exp_len;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_idle(input string name);
    check({name, "_wave"},   int'(osc_if.wave), 0);
    check({name, "_sample"}, int'(osc_if.sample), 0);
    check({name, "_tick"},   int'(osc_if.period_tick), 0);
    check({name, "_active"}, int'(osc_if.active), 0);
  endtask

  // Observes one period starting at the next negedge (count 0 expected there) until period_tick.
  task automatic play_period(input int drop_at, input int back_at, input int chg_at,
                             input int chg_kind, input logic [15:0] chg_val,
                             output int hi, output int lo, output int len, output int bad);
    logic signed [7:0] es;
    hi = 0; lo = 0; len = 0; bad = 0;
    for (int idx = 0; idx < 70000; idx++) begin
      @(negedge clk);
      if (osc_if.wave === 1'b1) hi++;
      else lo++;
      es = (osc_if.wave === 1'b1) ? 8'sd64 : -8'sd64;
      if (osc_if.active !== 1'b1 || osc_if.sample !== es) bad++;
      if (idx == drop_at) osc_if.key_on = 1'b0;
      if (idx == back_at) osc_if.key_on = 1'b1;
      if (idx == chg_at) begin
        if (chg_kind == 1) osc_if.div[9] = chg_val;
        else osc_if.note_sel = chg_val[3:0];
      end
      if (osc_if.period_tick === 1'b1) begin
        len = idx + 1;
        break;
      end
    end
  endtask

  task automatic check_period(input string name, input int hi, input int lo, input int len,
                              input int bad, input int e_hi, input int e_lo, input int e_len);
    check({name, "_len"}, len, e_len);
    check({name, "_hi"},  hi,  e_hi);
    check({name, "_lo"},  lo,  e_lo);
    check({name, "_sample_active"}, bad, 0);
  endtask

  initial begin
    int hi, lo, len, bad;

    osc_if.div      = '0;
    osc_if.note_sel = 4'd0;
    osc_if.key_on   = 1'b0;

    vecs[0] = '{note: 4'd3,  dv: 16'd1,  exp_hi: 1, exp_lo: 1, exp_len: 2};
    vecs[1] = '{note: 4'd5,  dv: 16'd0,  exp_hi: 1, exp_lo: 1, exp_len: 2};
    vecs[2] = '{note: 4'd7,  dv: 16'd2,  exp_hi: 1, exp_lo: 1, exp_len: 2};
    vecs[3] = '{note: 4'd2,  dv: 16'd3,  exp_hi: 1, exp_lo: 2, exp_len: 3};
    vecs[4] = '{note: 4'd11, dv: 16'd7,  exp_hi: 3, exp_lo: 4, exp_len: 7};
    vecs[5] = '{note: 4'd0,  dv: 16'd10, exp_hi: 5, exp_lo: 5, exp_len: 10};
    vecs[6] = '{note: 4'd13, dv: 16'd50, exp_hi: 0, exp_lo: 0, exp_len: 0};

    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("post_reset");

    // Single periods from IDLE; key drops on the first cycle so each ends back in IDLE.
    foreach (vecs[i]) begin
      if (vecs[i].note < 4'd12) osc_if.div[vecs[i].note] = vecs[i].dv;
      osc_if.note_sel = vecs[i].note;
      osc_if.key_on   = 1'b1;
      if (vecs[i].exp_len == 0) begin
        repeat (4) @(negedge clk);
        check($sformatf("vec%0d_invalid_active", i), int'(osc_if.active), 0);
        check($sformatf("vec%0d_invalid_wave", i),   int'(osc_if.wave), 0);
        osc_if.key_on = 1'b0;
        @(negedge clk);
      end else begin
        play_period(0, -1, -1, 0, 16'd0, hi, lo, len, bad);
        check_period($sformatf("vec%0d", i), hi, lo, len, bad,
                     vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_len);
        @(negedge clk);
        check($sformatf("vec%0d_idle_after", i), int'(osc_if.active), 0);
      end
    end

    // Note A, div9 shortened mid-period, then note C selected mid-period.
    osc_if.div[9]   = 16'd22727;
    osc_if.div[0]   = 16'd38223;
    osc_if.note_sel = 4'd9;
    osc_if.key_on   = 1'b1;
    play_period(-1, -1, 100, 1, 16'd11363, hi, lo, len, bad);
    check_period("a_22727", hi, lo, len, bad, 11363, 11364, 22727);
    play_period(-1, -1, 100, 2, 16'd0, hi, lo, len, bad);
    check_period("a_11363", hi, lo, len, bad, 5681, 5682, 11363);
    play_period(-1, -1, -1, 0, 16'd0, hi, lo, len, bad);
    check_period("c_38223", hi, lo, len, bad, 19111, 19112, 38223);

    // Reset mid-period must clear outputs before the next clock edge.
    repeat (50) @(negedge clk);
    check("pre_rst_active", int'(osc_if.active), 1);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    repeat (2) @(negedge clk);
    osc_if.key_on = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("rst_release");

    // Key released mid-period: STOP completes the period, then IDLE.
    osc_if.div[1]   = 16'd1000;
    osc_if.note_sel = 4'd1;
    osc_if.key_on   = 1'b1;
    play_period(500, -1, -1, 0, 16'd0, hi, lo, len, bad);
    check_period("stop", hi, lo, len, bad, 500, 500, 1000);
    @(negedge clk);
    check_idle("stop_idle");

    // Key released then re-pressed within the period: no restart, playback continues.
    osc_if.key_on = 1'b1;
    play_period(500, 600, -1, 0, 16'd0, hi, lo, len, bad);
    check_period("resume", hi, lo, len, bad, 500, 500, 1000);
    @(negedge clk);
    check("resume_next_active", int'(osc_if.active), 1);
    check("resume_next_wave",   int'(osc_if.wave), 1);
    osc_if.key_on = 1'b0;
    play_period(-1, -1, -1, 0, 16'd0, hi, lo, len, bad);
    check_period("resume_tail", hi, lo, len, bad, 499, 500, 999);
    @(negedge clk);
    check_idle("resume_idle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
